// File: rtl/prime_search.sv
// Trial-division prime finder: walks candidates upward from a start value and
// drives an external divrem unit one division at a time until a prime is found.
module prime_search #(
    parameter int WIDTH_LOG = 4,
    localparam int W = 1 << WIDTH_LOG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [W-1:0] start,
    output logic         ready,
    output logic         error,
    output logic [W-1:0] prime,
    output logic [W-1:0] count,
    output logic         div_go,
    output logic [W-1:0] div_num,
    output logic [W-1:0] div_den,
    input  logic         div_ready,
    input  logic         div_error,
    input  logic [W-1:0] div_quot,
    input  logic [W-1:0] div_rem
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_SENT  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] TWO      = W'(2);

    state_t       state_q, state_d;
    logic [W-1:0] c_q, c_d;
    logic [W-1:0] d_q, d_d;
    logic         ready_q, ready_d;
    logic         error_q, error_d;
    logic [W-1:0] prime_q, prime_d;
    logic [W-1:0] count_q, count_d;
    logic         div_go_q, div_go_d;
    logic [W-1:0] div_num_q, div_num_d;
    logic [W-1:0] div_den_q, div_den_d;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        if (v == ALL_ONES) begin
            return v;
        end else begin
            return v + W'(1);
        end
    endfunction

    // Next-state and output computation for the search sequencer.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        ready_d   = ready_q;
        error_d   = error_q;
        prime_d   = prime_q;
        count_d   = count_q;
        div_go_d  = 1'b0;
        div_num_d = div_num_q;
        div_den_d = div_den_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    c_d     = (start < TWO) ? TWO : start;
                    d_d     = TWO;
                    count_d = '0;
                    ready_d = 1'b0;
                    error_d = 1'b0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (div_ready) begin
                    div_go_d  = 1'b1;
                    div_num_d = c_q;
                    div_den_d = d_q;
                    count_d   = sat_inc(count_q);
                    state_d   = ST_SENT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_SENT: begin
                // divrem drops ready on this edge, so WAIT never sees a stale one
                div_go_d = 1'b0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_ready) begin
                    if (div_error) begin
                        error_d = 1'b1;
                        prime_d = '0;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (div_quot < d_q) begin
                        // quot < d with nonzero rem means d*d > c: no divisor left
                        prime_d = c_q;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else if (div_rem == '0) begin
                        if (c_q == ALL_ONES) begin
                            error_d = 1'b1;
                            prime_d = '0;
                            ready_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            c_d     = c_q + W'(1);
                            d_d     = TWO;
                            state_d = ST_ISSUE;
                        end
                    end else begin
                        d_d     = d_q + W'(1);
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            d_q       <= '0;
            ready_q   <= 1'b1;
            error_q   <= 1'b0;
            prime_q   <= '0;
            count_q   <= '0;
            div_go_q  <= 1'b0;
            div_num_q <= '0;
            div_den_q <= '0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            prime_q   <= prime_d;
            count_q   <= count_d;
            div_go_q  <= div_go_d;
            div_num_q <= div_num_d;
            div_den_q <= div_den_d;
        end
    end

    assign ready   = ready_q;
    assign error   = error_q;
    assign prime   = prime_q;
    assign count   = count_q;
    assign div_go  = div_go_q;
    assign div_num = div_num_q;
    assign div_den = div_den_q;

endmodule

// File: tb/tb_prime_search.sv
// Bench for prime_search: behavioural divrem, table of searches, scoreboarded results.
module tb_prime_search;

    logic        clk;
    logic        rst;
    logic        go;
    logic [15:0] start;
    logic        ready;
    logic        error;
    logic [15:0] prime;
    logic [15:0] count;
    logic        div_go;
    logic [15:0] div_num;
    logic [15:0] div_den;
    logic        dr_ready;
    logic        dr_error;
    logic [15:0] dr_quot;
    logic [15:0] dr_rem;
    logic [15:0] dr_num;
    logic [15:0] dr_den;
    int          dr_cnt;
    int          dr_lat_max;
    bit          inject_err;

    int total;
    int bad;
    int go_pulses;
    bit seq_on;
    bit prev_go;

    typedef struct packed {
        logic [15:0] prime;
        logic        err;
        logic [15:0] cnt;
    } res_t;

    typedef struct {
        logic [15:0] start;
        res_t        r;
    } vec_t;

    res_t        exp_q[$];
    logic [31:0] seq_q[$];
    vec_t        vecs[10];

    prime_search #(.WIDTH_LOG(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .start    (start),
        .ready    (ready),
        .error    (error),
        .prime    (prime),
        .count    (count),
        .div_go   (div_go),
        .div_num  (div_num),
        .div_den  (div_den),
        .div_ready(dr_ready),
        .div_error(dr_error),
        .div_quot (dr_quot),
        .div_rem  (dr_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider: drops ready on the edge that takes go, random latency.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dr_ready <= 1'b1;
            dr_error <= 1'b0;
            dr_quot  <= 16'd0;
            dr_rem   <= 16'd0;
            dr_num   <= 16'd0;
            dr_den   <= 16'd0;
            dr_cnt   <= 0;
        end else if (dr_ready) begin
            if (div_go) begin
                dr_num   <= div_num;
                dr_den   <= div_den;
                dr_ready <= 1'b0;
                dr_cnt   <= int'($urandom_range(0, dr_lat_max));
            end
        end else if (dr_cnt == 0) begin
            dr_quot  <= (dr_den == 16'd0) ? 16'hFFFF : dr_num / dr_den;
            dr_rem   <= (dr_den == 16'd0) ? dr_num : dr_num % dr_den;
            dr_error <= inject_err || (dr_den == 16'd0);
            dr_ready <= 1'b1;
        end else begin
            dr_cnt <= dr_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Division-request monitor: pulse spacing, operand sequence, operand stability.
    initial begin
        prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (div_go) begin
                go_pulses++;
                check("div_go_not_consecutive", {31'd0, prev_go}, 32'd0);
                if (seq_on) begin
                    if (seq_q.size() == 0) begin
                        check("extra_division", {16'd0, div_num}, 32'd0);
                    end else begin
                        check("div_num_den_seq", {div_num, div_den}, seq_q.pop_front());
                    end
                end
            end
            if (rst && !dr_ready && dr_cnt == 0) begin
                check("operands_stable", {div_num, div_den}, {dr_num, dr_den});
            end
            prev_go = div_go;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic push_seq(input logic [15:0] n, input int dlo, input int dhi);
        for (int k = dlo; k <= dhi; k++) begin
            seq_q.push_back({n, 16'(k)});
        end
    endtask

    // Call at a negedge; leaves go low one cycle later.
    task automatic start_go(input logic [15:0] s);
        go    = 1'b1;
        start = s;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Returns at the negedge of the first ready cycle, after scoring the result.
    task automatic wait_done(input string name);
        res_t e;
        int   n;
        n = 0;
        while (!ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        if (!ready) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_prime"}, {16'd0, prime}, {16'd0, e.prime});
            check({name, "_error"}, {31'd0, error}, {31'd0, e.err});
            check({name, "_count"}, {16'd0, count}, {16'd0, e.cnt});
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        go_pulses  = 0;
        seq_on     = 1'b0;
        inject_err = 1'b0;
        dr_lat_max = 3;
        rst        = 1'b0;
        go         = 1'b0;
        start      = 16'd0;

        vecs[0] = '{16'd0,     '{16'd2,     1'b0, 16'd1}};
        vecs[1] = '{16'd1,     '{16'd2,     1'b0, 16'd1}};
        vecs[2] = '{16'd2,     '{16'd2,     1'b0, 16'd1}};
        vecs[3] = '{16'd3,     '{16'd3,     1'b0, 16'd1}};
        vecs[4] = '{16'd4,     '{16'd5,     1'b0, 16'd3}};
        vecs[5] = '{16'd7,     '{16'd7,     1'b0, 16'd2}};
        vecs[6] = '{16'd24,    '{16'd29,    1'b0, 16'd14}};
        vecs[7] = '{16'd90,    '{16'd97,    1'b0, 16'd25}};
        vecs[8] = '{16'd65521, '{16'd65521, 1'b0, 16'd255}};
        vecs[9] = '{16'd65522, '{16'd0,     1'b1, 16'd53}};

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_prime", {16'd0, prime}, 32'd0);
        check("reset_count", {16'd0, count}, 32'd0);
        check("reset_div_go", {31'd0, div_go}, 32'd0);
        check("reset_div_ops", {div_num, div_den}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            go_pulses = 0;
            if (vecs[i].start == 16'd2) begin
                push_seq(16'd2, 2, 2);
                seq_on = 1'b1;
            end else if (vecs[i].start == 16'd24) begin
                push_seq(16'd24, 2, 2);
                push_seq(16'd25, 2, 5);
                push_seq(16'd26, 2, 2);
                push_seq(16'd27, 2, 3);
                push_seq(16'd28, 2, 2);
                push_seq(16'd29, 2, 6);
                seq_on = 1'b1;
            end else begin
                seq_on = 1'b0;
            end
            exp_q.push_back(vecs[i].r);
            start_go(vecs[i].start);
            wait_done($sformatf("search_%0d", vecs[i].start));
            if (seq_on) begin
                check("seq_all_issued", seq_q.size(), 32'd0);
                seq_q.delete();
            end
            if (vecs[i].start == 16'd2) begin
                check("start2_one_pulse", go_pulses, 32'd1);
            end
            seq_on = 1'b0;
            @(negedge clk);
        end

        // Divider error aborts the search on the first result.
        inject_err = 1'b1;
        exp_q.push_back('{16'd0, 1'b1, 16'd1});
        start_go(16'd24);
        wait_done("div_error");
        inject_err = 1'b0;
        @(negedge clk);

        // go/start activity during a search is ignored.
        exp_q.push_back('{16'd29, 1'b0, 16'd14});
        start_go(16'd24);
        repeat (5) begin
            go    = 1'b1;
            start = 16'd90;
            @(negedge clk);
            go    = 1'b0;
            start = 16'd65522;
            @(negedge clk);
        end
        wait_done("ignore_go");
        exp_q.push_back('{16'd3, 1'b0, 16'd1});
        start_go(16'd3);
        wait_done("back_to_back");
        @(negedge clk);

        // Reset while waiting on the divider.
        exp_q.push_back('{16'd0, 1'b0, 16'd0});
        start_go(16'd65521);
        begin
            int n;
            n = 0;
            while (!div_go && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("reset_test_div_go_seen", {31'd0, div_go}, 32'd1);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_div_go", {31'd0, div_go}, 32'd0);
        check("midrst_count", {16'd0, count}, 32'd0);
        check("midrst_prime", {16'd0, prime}, 32'd0);
        check("midrst_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.push_back('{16'd7, 1'b0, 16'd2});
        start_go(16'd7);
        wait_done("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prime_search.md
# prime_search

Sequencer that finds the smallest prime greater than or equal to a start value by trial division, driving an external `divrem` instance. It issues one division per candidate/divisor pair, decides from the quotient and remainder whether the candidate is prime, composite or still undecided, and steps candidate and divisor accordingly. It sits between the top-level generator control and the shared `divrem` datapath, and is that datapath's only requester.

## Interface

Parameters:
- WIDTH_LOG, 4, log2 of datapath width; W = 1 << WIDTH_LOG.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- go  in  1  start request; sampled only in IDLE.
- start  in  W  search start value; sampled with go.
- ready  out  1  1 = idle, result valid.
- error  out  1  1 = last search failed (no prime ≤ 2^W-1, or divider error).
- prime  out  W  prime found; 0 when error.
- count  out  W  divisions issued in last search, saturating at all-ones.
- div_go  out  1  to divrem go; one-cycle pulse per division.
- div_num  out  W  to divrem num (candidate).
- div_den  out  W  to divrem den (divisor).
- div_ready  in  1  from divrem ready.
- div_error  in  1  from divrem error.
- div_quot  in  W  from divrem quot.
- div_rem  in  W  from divrem rem.

## Operation

- Internal registers: candidate c (W), divisor d (W), state.
- States: IDLE, ISSUE, SENT, WAIT.
- IDLE: ready=1. On go: c <= (start < 2) ? 2 : start; d <= 2; count <= 0; ready <= 0; error <= 0; → ISSUE. Without go, hold all outputs.
- ISSUE: wait for div_ready=1; then div_go <= 1, div_num <= c, div_den <= d, count <= count+1 (saturating); → SENT.
- SENT: div_go is high for exactly this cycle; div_go <= 0; → WAIT.
- WAIT: on div_ready=1, evaluate in priority order:
  - div_error=1 → error <= 1, prime <= 0, ready <= 1; → IDLE.
  - div_quot < d → c is prime: prime <= c, ready <= 1; → IDLE. This covers c = d = 2.
  - div_rem == 0 → c is composite: if c == 2^W-1, then error <= 1, prime <= 0, ready <= 1, → IDLE; else c <= c+1, d <= 2, → ISSUE.
  - otherwise → d <= d+1; → ISSUE.
- Correctness: rem≠0 and quot<d imply d² > c, so all divisors ≤ √c have been checked. d never exceeds 2^(W/2), so it cannot overflow.
- div_num and div_den stay stable from ISSUE exit until WAIT exit.
- go while ready=0 is ignored; start changes are ignored outside IDLE.
- Comparisons are unsigned, W bits. c+1 never wraps: the all-ones check runs first.

## Timing

- Reset values (asynchronous): state=IDLE, ready=1, error=0, prime=0, count=0, div_go=0, div_num=0, div_den=0, c=0, d=0.
- Reset asserted mid-search aborts immediately; outputs take reset values at once. The external divrem is reset separately.
- All outputs are registered; no combinational input→output paths.
- div_go is high one cycle per division, never in two consecutive cycles.
- SENT exists because divrem drops ready on the same edge that samples go. WAIT therefore never sees a stale div_ready.
- Per-division overhead: ISSUE (≥1 cycle) + SENT (1) + divrem busy time + 1 evaluation edge.
- Search latency is data-dependent. ready rises on the edge after the final evaluation; go is accepted again on the next cycle.

## Test plan

- start=2, go pulse → ready=1, error=0, prime=2, count=1; exactly one div_go pulse with div_num=2, div_den=2.
- start=0 then start=1 → prime=2, count=1 each.
- start=24 → prime=29, count=14; check the div_num/div_den sequence 24/2, 25/2..25/5, 26/2, 27/2, 27/3, 28/2, 29/2..29/6.
- start=65521 (W=16) → prime=65521, error=0. start=65522 → error=1, prime=0, ready=1, no wrap to low candidates.
- go pulsed repeatedly with changing start during a search → no effect, the original result is returned. A back-to-back go on the first ready cycle starts a new search.
- rst=0 asserted while in WAIT → same cycle ready=1, div_go=0, count=0, prime=0. After release, start=7 → prime=7, count=2.
